// File: rtl/norm2_pkg.sv
// rtl/norm2_pkg.sv - shared widths, state encoding and helpers for the norm2 sequencer
package norm2_pkg;

  localparam int ARR_LEN_DEF = 1000;
  localparam int ADDR_W      = 10;
  localparam int DATA_W      = 27;
  localparam int RES_W       = 64;
  localparam int CYC_W       = 32;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    ZFILL,
    START,
    RUN,
    DONE
  } state_e;

  function automatic logic [CYC_W-1:0] sat_inc(input logic [CYC_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/norm2_seq_wdog.sv
// rtl/norm2_seq_wdog.sv - RUN-cycle watchdog, flags the cycle that reaches TIMEOUT_CYC
module norm2_seq_wdog
  import norm2_pkg::*;
#(
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int W = $clog2(TIMEOUT_CYC + 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire = en && (cnt_q == W'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/norm2_seq.sv
// rtl/norm2_seq.sv - loads the kernel array RAM, fires the kernel, captures its result
// NORM2_SEQ_TIMEOUT_EN adds a RUN watchdog that aborts after TIMEOUT_CYC cycles.
module norm2_seq
  import norm2_pkg::*;
#(
  parameter int ARR_LEN     = ARR_LEN_DEF,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cmd_start,
  output logic                     busy,
  input  logic                     in_valid,
  input  logic                     in_last,
  input  logic signed [DATA_W-1:0] in_data,
  output logic                     in_ready,
  output logic                     controlArr,
  output logic                     controlArrWEnable_a,
  output logic [ADDR_W-1:0]        controlArrAddr_a,
  output logic signed [DATA_W-1:0] controlArrWData_a,
  output logic                     r_enable,
  output logic [ADDR_W-1:0]        init_i,
  output logic signed [RES_W-1:0]  init_acc,
  input  logic                     w_enable,
  input  logic signed [RES_W-1:0]  result,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [RES_W-1:0]  out_data,
  output logic [CYC_W-1:0]         out_cycles,
  output logic                     out_err
);

  // One spare bit lets the count reach ARR_LEN, marking "all addresses issued".
  localparam int                CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0]  LEN_C = CNT_W'(ARR_LEN);
  localparam logic [CYC_W-1:0]  TO_C  = CYC_W'(TIMEOUT_CYC);

  state_e                     state_q, state_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic [CYC_W-1:0]           cyc_q, cyc_d;
  logic                       len_err_q, len_err_d;
  logic                       timeout_q, timeout_d;
  logic                       we_q, we_d;
  logic [ADDR_W-1:0]          addr_q, addr_d;
  logic signed [DATA_W-1:0]   wdata_q, wdata_d;
  logic                       r_en_q, r_en_d;
  logic                       out_valid_q, out_valid_d;
  logic signed [RES_W-1:0]    out_data_q, out_data_d;
  logic [CYC_W-1:0]           out_cycles_q, out_cycles_d;
  logic                       expire;
  logic                       accept;

`ifdef NORM2_SEQ_TIMEOUT_EN
  norm2_seq_wdog #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_wdog (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (state_q == START),
    .en    (state_q == RUN),
    .expire(expire)
  );
`else
  assign expire = 1'b0;
`endif

  // in_ready drops once the final beat is in, so the drain cycle lets its write land.
  assign in_ready = (state_q == LOAD) && (cnt_q != LEN_C);
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    cyc_d        = cyc_q;
    len_err_d    = len_err_q;
    timeout_d    = timeout_q;
    we_d         = 1'b0;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    out_data_d   = out_data_q;
    out_cycles_d = out_cycles_q;
    case (state_q)
      IDLE: begin
        if (cmd_start) begin
          state_d = LOAD;
          cnt_d   = '0;
        end
      end
      LOAD: begin
        if (cnt_q == LEN_C) begin
          state_d = START;
        end else if (accept) begin
          we_d    = 1'b1;
          addr_d  = cnt_q[ADDR_W-1:0];
          wdata_d = in_data;
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == LEN_C - 1'b1) begin
            if (!in_last) len_err_d = 1'b1;
          end else if (in_last) begin
            state_d = ZFILL;
          end
        end
      end
      ZFILL: begin
        if (cnt_q == LEN_C) begin
          state_d = START;
        end else begin
          we_d    = 1'b1;
          addr_d  = cnt_q[ADDR_W-1:0];
          wdata_d = '0;
          cnt_d   = cnt_q + 1'b1;
        end
      end
      START: begin
        cyc_d   = '0;
        state_d = RUN;
      end
      RUN: begin
        cyc_d = sat_inc(cyc_q);
        if (w_enable) begin
          out_data_d   = result;
          out_cycles_d = sat_inc(cyc_q);
          state_d      = DONE;
        end else if (expire) begin
          out_data_d   = '0;
          out_cycles_d = TO_C;
          timeout_d    = 1'b1;
          state_d      = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          len_err_d = 1'b0;
          timeout_d = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    r_en_d      = (state_d == START);
    out_valid_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      cyc_q        <= '0;
      len_err_q    <= 1'b0;
      timeout_q    <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      r_en_q       <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_cycles_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      cyc_q        <= cyc_d;
      len_err_q    <= len_err_d;
      timeout_q    <= timeout_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      r_en_q       <= r_en_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_cycles_q <= out_cycles_d;
    end
  end

  assign busy                = (state_q != IDLE);
  assign controlArr          = !((state_q == START) || (state_q == RUN));
  assign controlArrWEnable_a = we_q;
  assign controlArrAddr_a    = addr_q;
  assign controlArrWData_a   = wdata_q;
  assign r_enable            = r_en_q;
  assign init_i              = '0;
  assign init_acc            = '0;
  assign out_valid           = out_valid_q;
  assign out_data            = out_data_q;
  assign out_cycles          = out_cycles_q;
  assign out_err             = len_err_q | timeout_q;

endmodule

// File: tb/tb_norm2_seq.sv
// tb/tb_norm2_seq.sv - directed bench for norm2_seq with RAM and kernel models
module tb_norm2_seq;

`ifdef NORM2_SEQ_TIMEOUT_EN
  localparam int TO = 16;
`else
  localparam int TO = 4096;
`endif
  localparam int N    = 1000;
  localparam int KLAT = 5;

  logic               clk, rst_n, cmd_start, busy;
  logic               in_valid, in_last, in_ready;
  logic signed [26:0] in_data;
  logic               controlArr, controlArrWEnable_a;
  logic [9:0]         controlArrAddr_a;
  logic signed [26:0] controlArrWData_a;
  logic               r_enable;
  logic [9:0]         init_i;
  logic signed [63:0] init_acc;
  logic               w_enable;
  logic signed [63:0] result;
  logic               out_valid, out_ready;
  logic signed [63:0] out_data;
  logic [31:0]        out_cycles;
  logic               out_err;

  norm2_seq #(.ARR_LEN(N), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_start(cmd_start), .busy(busy),
    .in_valid(in_valid), .in_last(in_last), .in_data(in_data), .in_ready(in_ready),
    .controlArr(controlArr), .controlArrWEnable_a(controlArrWEnable_a),
    .controlArrAddr_a(controlArrAddr_a), .controlArrWData_a(controlArrWData_a),
    .r_enable(r_enable), .init_i(init_i), .init_acc(init_acc),
    .w_enable(w_enable), .result(result), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_cycles(out_cycles), .out_err(out_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  logic signed [26:0] stim [N];
  logic signed [26:0] mem  [N];
  int  wr_cnt = 0, viol_cnt = 0, ren_cnt = 0;
  bit  poison_req = 0, poison_ack = 0;
  bit  kernel_on = 1;
  int  force_req = 0, force_seen = 0;
  int  kcnt = -1;

  function automatic longint ksum();
    longint s = 0;
    for (int i = 0; i < N; i++) begin
      longint v;
      v = mem[i];
      s += v * v;
    end
    return s;
  endfunction

  function automatic longint stim_sum(input int n);
    longint s = 0;
    for (int i = 0; i < n; i++) begin
      longint v;
      v = stim[i];
      s += v * v;
    end
    return s;
  endfunction

  // RAM model and write-ownership monitor
  initial begin
    forever begin
      @(negedge clk);
      if (poison_req != poison_ack) begin
        for (int i = 0; i < N; i++) mem[i] = 27'sd7;
        poison_ack = poison_req;
      end
      if (controlArrWEnable_a) begin
        wr_cnt++;
        if (!controlArr || controlArrAddr_a >= 10'(N)) viol_cnt++;
        else mem[controlArrAddr_a] = controlArrWData_a;
      end
      if (r_enable) ren_cnt++;
    end
  end

  // Kernel model: answers KLAT cycles after r_enable with the sum of squares of the RAM
  initial begin
    w_enable = 1'b0;
    result   = '0;
    forever begin
      @(negedge clk);
      w_enable = 1'b0;
      if (force_req != force_seen) begin
        force_seen = force_req;
        w_enable   = 1'b1;
        result     = 64'sd777;
      end else if (kcnt > 0) begin
        kcnt--;
        if (kcnt == 0) begin
          result   = ksum();
          w_enable = 1'b1;
          kcnt     = -1;
        end
      end else if (r_enable && kernel_on) begin
        kcnt = KLAT;
      end
    end
  end

  task automatic do_start();
    @(negedge clk);
    cmd_start = 1'b1;
    @(negedge clk);
    cmd_start = 1'b0;
  endtask

  task automatic load(input int n, input int last_at, input bit hold_extra);
    int i = 0;
    int guard = 0;
    while (i < n && guard < 4 * N) begin
      @(negedge clk);
      guard++;
      in_valid = 1'b1;
      in_data  = stim[i];
      in_last  = (i == last_at);
      if (in_ready) i++;
    end
    n_cmp++;
    if (i != n) begin
      n_fail++;
      $display("FAIL load_accept: beats accepted %0d, required %0d", i, n);
    end
    @(negedge clk);
    if (hold_extra) begin
      in_valid = 1'b1;
      in_data  = 27'sd99;
      in_last  = 1'b1;
    end else begin
      in_valid = 1'b0;
      in_last  = 1'b0;
    end
  endtask

  task automatic wait_done();
    int g = 0;
    while (!out_valid && g < 3000) begin
      @(negedge clk);
      g++;
    end
    n_cmp++;
    if (out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL wait_done: out_valid %b after %0d cycles, required 1", out_valid, g);
    end
  endtask

  task automatic wait_ren();
    int g = 0;
    while (!r_enable && g < 3000) begin
      @(negedge clk);
      g++;
    end
    n_cmp++;
    if (r_enable !== 1'b1) begin
      n_fail++;
      $display("FAIL wait_ren: r_enable %b after %0d cycles, required 1", r_enable, g);
    end
  endtask

  task automatic finish_done();
    @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    n_cmp++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL done_exit: busy %b out_valid %b, required 0 0", busy, out_valid);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({busy, controlArr, in_ready, out_valid, out_err, r_enable, controlArrWEnable_a} !== 7'b0100000) begin
      n_fail++;
      $display("FAIL reset_flags: got %b required 0100000",
               {busy, controlArr, in_ready, out_valid, out_err, r_enable, controlArrWEnable_a});
    end
    n_cmp++;
    if (out_data !== 64'sd0 || out_cycles !== 32'd0 || controlArrAddr_a !== 10'd0 || controlArrWData_a !== 27'sd0) begin
      n_fail++;
      $display("FAIL reset_data: data %0d cycles %0d addr %0d wdata %0d, required all 0",
               out_data, out_cycles, controlArrAddr_a, controlArrWData_a);
    end
    n_cmp++;
    if (init_i !== 10'd0 || init_acc !== 64'sd0) begin
      n_fail++;
      $display("FAIL init_consts: init_i %0d init_acc %0d, required 0 0", init_i, init_acc);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset_idle: busy %b in_ready %b, required 0 0", busy, in_ready);
    end
  endtask

  task automatic test_full();
    int w0, r0, v0, bad;
    longint exp_s;
    for (int i = 0; i < N; i++) stim[i] = (i % 2 == 0) ? 27'(i * 1000 + 7) : 27'(-(i * 777));
    stim[0] = {1'b1, 26'd0};
    exp_s = stim_sum(N);
    w0 = wr_cnt; r0 = ren_cnt; v0 = viol_cnt;
    do_start();
    load(N, N - 1, 1'b0);
    wait_done();
    n_cmp++;
    if (out_data !== exp_s) begin
      n_fail++;
      $display("FAIL full_data: got %0d required %0d", out_data, exp_s);
    end
    n_cmp++;
    if (out_err !== 1'b0 || out_cycles !== 32'(KLAT)) begin
      n_fail++;
      $display("FAIL full_status: err %b cycles %0d, required 0 %0d", out_err, out_cycles, KLAT);
    end
    n_cmp++;
    if (ren_cnt - r0 != 1) begin
      n_fail++;
      $display("FAIL full_ren_count: got %0d required 1", ren_cnt - r0);
    end
    n_cmp++;
    if (wr_cnt - w0 != N || viol_cnt != v0) begin
      n_fail++;
      $display("FAIL full_writes: writes %0d violations %0d, required %0d 0", wr_cnt - w0, viol_cnt - v0, N);
    end
    bad = 0;
    for (int i = 0; i < N; i++) if (mem[i] !== stim[i]) bad++;
    n_cmp++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL full_ram_image: %0d wrong words, required 0", bad);
    end
    finish_done();
  endtask

  task automatic test_short();
    int w0, bad;
    poison_req = ~poison_req;
    repeat (2) @(negedge clk);
    stim[0] = 27'sd5; stim[1] = -27'sd3; stim[2] = 27'sd2;
    w0 = wr_cnt;
    do_start();
    load(3, 2, 1'b0);
    wait_done();
    n_cmp++;
    if (out_data !== 64'sd38 || out_err !== 1'b0) begin
      n_fail++;
      $display("FAIL short_data: data %0d err %b, required 38 0", out_data, out_err);
    end
    bad = 0;
    for (int i = 3; i < N; i++) if (mem[i] !== 27'sd0) bad++;
    n_cmp++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL short_zfill: %0d nonzero words in 3..999, required 0", bad);
    end
    n_cmp++;
    if (mem[0] !== 27'sd5 || mem[1] !== -27'sd3 || mem[2] !== 27'sd2 || wr_cnt - w0 != N) begin
      n_fail++;
      $display("FAIL short_head: %0d %0d %0d writes %0d, required 5 -3 2 %0d",
               mem[0], mem[1], mem[2], wr_cnt - w0, N);
    end
    finish_done();
  endtask

  task automatic test_len_err();
    int w0;
    logic signed [63:0] d0;
    logic [31:0] c0;
    for (int i = 0; i < N; i++) stim[i] = 27'(i - 500);
    w0 = wr_cnt;
    do_start();
    load(N, -1, 1'b1);
    wait_done();
    n_cmp++;
    if (out_err !== 1'b1 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL len_err_flags: err %b in_ready %b, required 1 0", out_err, in_ready);
    end
    n_cmp++;
    if (out_data !== 64'sd83333500) begin
      n_fail++;
      $display("FAIL len_err_data: got %0d required 83333500", out_data);
    end
    n_cmp++;
    if (wr_cnt - w0 != N) begin
      n_fail++;
      $display("FAIL len_err_writes: got %0d required %0d", wr_cnt - w0, N);
    end
    d0 = out_data;
    c0 = out_cycles;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      cmd_start = (k == 3);
      n_cmp++;
      if (out_valid !== 1'b1 || out_data !== d0 || out_cycles !== c0 || out_err !== 1'b1) begin
        n_fail++;
        $display("FAIL done_hold[%0d]: valid %b data %0d cycles %0d err %b, required 1 %0d %0d 1",
                 k, out_valid, out_data, out_cycles, out_err, d0, c0);
      end
    end
    cmd_start = 1'b0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    finish_done();
    @(negedge clk);
    n_cmp++;
    if (out_err !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL len_err_clear: err %b busy %b, required 0 0", out_err, busy);
    end
  endtask

  task automatic test_reset_run();
    int w0, r0;
    kernel_on = 0;
    stim[0] = 27'sd1; stim[1] = 27'sd2; stim[2] = 27'sd3;
    do_start();
    load(3, 2, 1'b0);
    wait_ren();
    repeat (8) @(negedge clk);
    n_cmp++;
    if (busy !== 1'b1 || controlArr !== 1'b0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL in_run: busy %b ctrl %b valid %b, required 1 0 0", busy, controlArr, out_valid);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (controlArr !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 || r_enable !== 1'b0 || controlArrWEnable_a !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: ctrl %b busy %b valid %b ren %b we %b, required 1 0 0 0 0",
               controlArr, busy, out_valid, r_enable, controlArrWEnable_a);
    end
    @(negedge clk);
    rst_n = 1'b1;
    w0 = wr_cnt; r0 = ren_cnt;
    force_req++;
    repeat (5) @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || out_data !== 64'sd0) begin
      n_fail++;
      $display("FAIL late_w_enable: valid %b busy %b data %0d, required 0 0 0", out_valid, busy, out_data);
    end
    n_cmp++;
    if (wr_cnt != w0 || ren_cnt != r0) begin
      n_fail++;
      $display("FAIL post_reset_activity: writes %0d r_enables %0d, required 0 0", wr_cnt - w0, ren_cnt - r0);
    end
    kernel_on = 1;
  endtask

`ifdef NORM2_SEQ_TIMEOUT_EN
  task automatic test_timeout();
    int k = 0;
    kernel_on = 0;
    do_start();
    load(3, 2, 1'b0);
    wait_ren();
    while (!out_valid && k < 100) begin
      @(negedge clk);
      k++;
    end
    n_cmp++;
    if (k != 17) begin
      n_fail++;
      $display("FAIL timeout_latency: DONE %0d cycles after START, required 17", k);
    end
    n_cmp++;
    if (out_err !== 1'b1 || out_data !== 64'sd0 || out_cycles !== 32'd16) begin
      n_fail++;
      $display("FAIL timeout_result: err %b data %0d cycles %0d, required 1 0 16", out_err, out_data, out_cycles);
    end
    finish_done();
    n_cmp++;
    if (out_err !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_clear: err %b required 0", out_err);
    end
    kernel_on = 1;
  endtask
`else
  task automatic test_no_timeout();
    kernel_on = 0;
    do_start();
    load(3, 2, 1'b0);
    wait_ren();
    repeat (200) @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0 || busy !== 1'b1 || controlArr !== 1'b0 || out_err !== 1'b0) begin
      n_fail++;
      $display("FAIL no_timeout: valid %b busy %b ctrl %b err %b, required 0 1 0 0",
               out_valid, busy, controlArr, out_err);
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    kernel_on = 1;
  endtask
`endif

  initial begin
    rst_n     = 1'b0;
    cmd_start = 1'b0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    test_reset();
    test_full();
    test_short();
    test_len_err();
    test_reset_run();
`ifdef NORM2_SEQ_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/norm2_seq.md
NORM2_SEQ -- requirements
Module: norm2_seq

Interface
REQ-001 SHALL have parameter ARR_LEN, 1000, number of array elements the kernel reads per run.
REQ-002 SHALL have parameter TIMEOUT_CYC, 4096, maximum run cycles before abort (used only with NORM2_SEQ_TIMEOUT_EN).
REQ-003 SHALL have ports:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cmd_start  in  1  one-cycle request to begin a load+run.
- busy  out  1  high in every state except IDLE.
- in_valid, in_last  in  1 each  input sample stream.
- in_data  in  27 signed  sample.
- in_ready  out  1  stream accept.
- controlArr  out  1  1 = array RAM port a owned by this block.
- controlArrWEnable_a  out  1  RAM write enable.
- controlArrAddr_a  out  10  RAM address.
- controlArrWData_a  out  27 signed  RAM write data.
- r_enable  out  1  kernel start pulse.
- init_i  out  10  kernel loop start, constant 0.
- init_acc  out  64 signed  kernel accumulator init, constant 0.
- w_enable  in  1  kernel done pulse.
- result  in  64 signed  kernel result, valid with w_enable.
- out_valid  out  1  result available.
- out_ready  in  1  result consumer accept.
- out_data  out  64 signed  captured result.
- out_cycles  out  32  cycles from r_enable to w_enable.
- out_err  out  1  timeout or length error.

Function
REQ-004 SHALL implement states IDLE, LOAD, ZFILL, START, RUN, DONE.
REQ-005 IDLE -> LOAD on cmd_start; cmd_start SHALL be ignored in every other state.
REQ-006 LOAD: in_ready=1; each accepted beat (in_valid & in_ready) SHALL write in_data to address = beat count.
REQ-007 RAM outputs SHALL be registered: a beat accepted at cycle t drives WEnable/Addr/WData in cycle t+1; WEnable=0 otherwise.
REQ-008 LOAD -> ZFILL when in_last is accepted with count < ARR_LEN-1; LOAD -> START when beat ARR_LEN-1 is accepted.
REQ-009 If beat ARR_LEN-1 has in_last=0, a sticky len_err SHALL be set; in_ready SHALL be 0 outside LOAD, so excess beats stay held upstream.
REQ-010 ZFILL SHALL write 0 to every remaining address, one per cycle, up to ARR_LEN-1, then -> START.
REQ-011 controlArr SHALL be 1 in IDLE, LOAD, ZFILL, DONE and 0 in START and RUN; START SHALL be entered only after the last RAM write cycle has completed.
REQ-012 START SHALL last exactly one cycle with r_enable=1, then -> RUN; r_enable=0 in all other states.
REQ-013 RUN: cycle counter SHALL increment each cycle; on w_enable capture result into out_data and count into out_cycles, -> DONE.
REQ-014 w_enable outside RUN SHALL be ignored.
REQ-015 DONE: out_valid=1, out_data/out_cycles/out_err stable; on out_ready -> IDLE, clear len_err.
REQ-016 out_err SHALL equal len_err OR timeout flag.
REQ-017 Counters SHALL wrap at their width; out_cycles saturates at 2^32-1.

Reset
REQ-018 On rst_n low, asynchronously: state IDLE, controlArr=1, r_enable=0, WEnable=0, Addr=0, WData=0, in_ready=0, out_valid=0, out_data=0, out_cycles=0, out_err=0, all counters 0.
REQ-019 Reset mid-LOAD/RUN SHALL abandon the run with no further RAM writes or r_enable pulse.

Configuration
REQ-020 With NORM2_SEQ_TIMEOUT_EN defined, RUN reaching TIMEOUT_CYC cycles without w_enable SHALL -> DONE with out_err=1, out_data=0, out_cycles=TIMEOUT_CYC.
REQ-021 Without NORM2_SEQ_TIMEOUT_EN, RUN waits indefinitely and timeout flag is constant 0.

Structure
REQ-022 Package norm2_pkg SHALL hold ARR_LEN default, widths (ADDR 10, DATA 27, RES 64, CYC 32) and the state enum.
REQ-023 Timeout counter SHALL be sub-module norm2_seq_wdog, instantiated only under NORM2_SEQ_TIMEOUT_EN.

Verification
REQ-024 1000 beats, last on beat 999, kernel model -> out_data = sum of squares, out_err=0, exactly one r_enable.
REQ-025 3 beats {5,-3,2}, last on beat 2 -> addresses 3..999 written 0, out_data=38.
REQ-026 1000 beats, in_last=0 on beat 999 -> out_err=1, in_ready=0 in DONE, result still captured.
REQ-027 out_ready held 0 for 10 cycles in DONE -> out_valid and out_data stable, cmd_start ignored.
REQ-028 rst_n low during RUN -> next cycle controlArr=1, out_valid=0, state IDLE; late w_enable ignored.
REQ-029 With NORM2_SEQ_TIMEOUT_EN, TIMEOUT_CYC=16, kernel never responds -> DONE after 16 RUN cycles, out_err=1, out_data=0.
